// File: rtl/regbank_arbiter.sv
// -----------------------------------------------------------------------------
// regbank_arbiter
//
// Purpose:
//   Shares one register bank between two requesters, A and B. Each granted
//   transaction reads two registers and can also write one register. It goes
//   through three states:
//     IDLE    : the winning request is latched and its Gnt pulses combinationally
//     ISSUE   : addresses, data and strobes are driven to the bank for one cycle
//     CAPTURE : the bank's registered outputs are sampled into Rdata1/Rdata2
//   The owner's Valid pulses in the cycle after CAPTURE, which is back in IDLE.
//   That cycle is three cycles after its Gnt. A new grant can be issued in the
//   same cycle.
//
// Configuration macro:
//   REGBANK_ARB_ROUND_ROBIN_EN
//     defined   : a tie goes to the requester that was not granted most
//                 recently. A one-bit pointer tracks this, and its reset value
//                 favours A.
//     undefined : fixed priority. A always wins a tie, and there is no pointer
//                 register.
//
// Ports:
//   Clock_in             in   clock; all state changes happen on posedge
//   Signal_reset         in   asynchronous active-high reset
//   Req_A / Req_B        in   transaction requests
//   Wr_A / Wr_B          in   the transaction includes a write
//   Rd1_*, Rd2_*         in   read addresses       [ADDR_W]
//   Waddr_*              in   write address        [ADDR_W]
//   Wdata_*              in   write data           [DATA_W]
//   Gnt_A / Gnt_B        out  one-cycle pulse: request latched
//   Valid_A / Valid_B    out  one-cycle pulse: Rdata1/Rdata2 hold that owner's result
//   Rdata1 / Rdata2      out  read results; they hold their value until the next Valid
//   Read_1, Read_2       out  bank read addresses
//   Address_to_write     out  bank write address
//   Data_to_write        out  bank write data
//   Signal_write         out  bank write strobe (ISSUE cycle only)
//   Signal_read          out  bank read strobe  (ISSUE cycle only)
//   Out_1 / Out_2        in   bank read data, registered in the bank on posedge
//   Busy                 out  high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module regbank_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              Clock_in,
  input  logic              Signal_reset,
  input  logic              Req_A,
  input  logic              Req_B,
  input  logic              Wr_A,
  input  logic              Wr_B,
  input  logic [ADDR_W-1:0] Rd1_A,
  input  logic [ADDR_W-1:0] Rd2_A,
  input  logic [ADDR_W-1:0] Rd1_B,
  input  logic [ADDR_W-1:0] Rd2_B,
  input  logic [ADDR_W-1:0] Waddr_A,
  input  logic [ADDR_W-1:0] Waddr_B,
  input  logic [DATA_W-1:0] Wdata_A,
  input  logic [DATA_W-1:0] Wdata_B,
  output logic              Gnt_A,
  output logic              Gnt_B,
  output logic              Valid_A,
  output logic              Valid_B,
  output logic [DATA_W-1:0] Rdata1,
  output logic [DATA_W-1:0] Rdata2,
  output logic [ADDR_W-1:0] Read_1,
  output logic [ADDR_W-1:0] Read_2,
  output logic [ADDR_W-1:0] Address_to_write,
  output logic [DATA_W-1:0] Data_to_write,
  output logic              Signal_write,
  output logic              Signal_read,
  input  logic [DATA_W-1:0] Out_1,
  input  logic [DATA_W-1:0] Out_2,
  output logic              Busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t              state_reg;
  logic                owner_b_reg;
  logic                valid_a_reg;
  logic                valid_b_reg;
  logic [DATA_W-1:0]   rdata1_reg;
  logic [DATA_W-1:0]   rdata2_reg;
  logic [ADDR_W-1:0]   read_1_reg;
  logic [ADDR_W-1:0]   read_2_reg;
  logic [ADDR_W-1:0]   waddr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic                signal_write_reg;
  logic                signal_read_reg;

  logic                pick_a;
  logic                pick_b;
  logic                grant_a;
  logic                grant_b;
  logic                grant_any;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef REGBANK_ARB_ROUND_ROBIN_EN
  // last_b_reg = 1 means B was granted most recently, so A wins the next tie.
  // It resets to 1 so that A wins the first tie after reset.
  logic last_b_reg;

  assign pick_a = Req_A & (~Req_B | last_b_reg);

  always_ff @(posedge Clock_in or posedge Signal_reset) begin
    if (Signal_reset) begin
      last_b_reg <= 1'b1;
    end else if (grant_any) begin
      last_b_reg <= grant_b;
    end
  end
`else
  assign pick_a = Req_A;
`endif

  assign pick_b = Req_B & ~pick_a;

  // Gnt is combinational so that it can pulse in the IDLE cycle that latches
  // the request. It is gated by reset, so that no grant appears while the
  // FSM is held in reset.
  assign grant_a   = (state_reg == IDLE) & pick_a & ~Signal_reset;
  assign grant_b   = (state_reg == IDLE) & pick_b & ~Signal_reset;
  assign grant_any = grant_a | grant_b;

  // ---------------------------------------------------------------------------
  // Transaction FSM. The bank-facing outputs are loaded on the grant edge.
  // This makes them valid for exactly the ISSUE cycle and lets the
  // asynchronous reset clear them directly.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock_in or posedge Signal_reset) begin
    if (Signal_reset) begin
      state_reg        <= IDLE;
      owner_b_reg      <= 1'b0;
      valid_a_reg      <= 1'b0;
      valid_b_reg      <= 1'b0;
      rdata1_reg       <= '0;
      rdata2_reg       <= '0;
      read_1_reg       <= '0;
      read_2_reg       <= '0;
      waddr_reg        <= '0;
      wdata_reg        <= '0;
      signal_write_reg <= 1'b0;
      signal_read_reg  <= 1'b0;
    end else begin
      // Pulses and strobes fall by default and are raised only where needed.
      valid_a_reg      <= 1'b0;
      valid_b_reg      <= 1'b0;
      signal_write_reg <= 1'b0;
      signal_read_reg  <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (grant_any) begin
            state_reg        <= ISSUE;
            owner_b_reg      <= grant_b;
            read_1_reg       <= grant_b ? Rd1_B   : Rd1_A;
            read_2_reg       <= grant_b ? Rd2_B   : Rd2_A;
            waddr_reg        <= grant_b ? Waddr_B : Waddr_A;
            wdata_reg        <= grant_b ? Wdata_B : Wdata_A;
            signal_write_reg <= grant_b ? Wr_B    : Wr_A;
            signal_read_reg  <= 1'b1;
          end
        end

        ISSUE: begin
          // The bank samples the addresses and performs the write on this edge.
          // Its registered read outputs then carry the values from before the
          // write.
          state_reg <= CAPTURE;
        end

        CAPTURE: begin
          state_reg   <= IDLE;
          rdata1_reg  <= Out_1;
          rdata2_reg  <= Out_2;
          valid_a_reg <= ~owner_b_reg;
          valid_b_reg <= owner_b_reg;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign Gnt_A            = grant_a;
  assign Gnt_B            = grant_b;
  assign Valid_A          = valid_a_reg;
  assign Valid_B          = valid_b_reg;
  assign Rdata1           = rdata1_reg;
  assign Rdata2           = rdata2_reg;
  assign Read_1           = read_1_reg;
  assign Read_2           = read_2_reg;
  assign Address_to_write = waddr_reg;
  assign Data_to_write    = wdata_reg;
  assign Signal_write     = signal_write_reg;
  assign Signal_read      = signal_read_reg;
  assign Busy             = (state_reg != IDLE);

endmodule

// File: tb/tb_regbank_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regbank_arbiter
//
// This testbench instantiates regbank_arbiter together with a small register
// bank. A negedge monitor records grants, valids and write strobes into
// queues. Each test task drives its scenario and then compares the recorded
// events with a transaction-level model. The model keeps a shadow copy of the
// register contents and remembers which requester was granted last.
// -----------------------------------------------------------------------------
module tb_regbank_arbiter;
  localparam int AW = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_a, req_b, wr_a, wr_b;
  logic [AW-1:0] rd1_a, rd2_a, rd1_b, rd2_b, waddr_a, waddr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          gnt_a, gnt_b, val_a, val_b;
  logic [DW-1:0] rdata1, rdata2;
  logic [AW-1:0] rd_1, rd_2, waddr_o;
  logic [DW-1:0] wdata_o;
  logic          sig_write, sig_read, busy;
  logic [DW-1:0] out1, out2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  regbank_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .Clock_in(clk), .Signal_reset(rst),
    .Req_A(req_a), .Req_B(req_b), .Wr_A(wr_a), .Wr_B(wr_b),
    .Rd1_A(rd1_a), .Rd2_A(rd2_a), .Rd1_B(rd1_b), .Rd2_B(rd2_b),
    .Waddr_A(waddr_a), .Waddr_B(waddr_b), .Wdata_A(wdata_a), .Wdata_B(wdata_b),
    .Gnt_A(gnt_a), .Gnt_B(gnt_b), .Valid_A(val_a), .Valid_B(val_b),
    .Rdata1(rdata1), .Rdata2(rdata2), .Read_1(rd_1), .Read_2(rd_2),
    .Address_to_write(waddr_o), .Data_to_write(wdata_o),
    .Signal_write(sig_write), .Signal_read(sig_read),
    .Out_1(out1), .Out_2(out2), .Busy(busy)
  );

  // ---------------- register bank (registered read, no bypass) ---------------
  logic [DW-1:0] mem [16];
  logic          bank_init;

  function automatic logic [DW-1:0] init_val(input int i);
    logic [DW-1:0] v;
    v = 32'h5A5A0000 + i * 32'h01010101;
    if (i == 5) v = '0;
    return v;
  endfunction

  always @(posedge clk) begin
    if (bank_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
    end else begin
      if (sig_read) begin
        out1 <= mem[rd_1];
        out2 <= mem[rd_2];
      end
      if (sig_write) mem[waddr_o] <= wdata_o;
    end
  end

  // ---------------- event monitor ----------------
  typedef struct {
    bit owner_b; int cyc; bit req_a; bit req_b; bit wr;
    logic [AW-1:0] rd1; logic [AW-1:0] rd2; logic [AW-1:0] waddr; logic [DW-1:0] wdata;
  } gnt_ev_t;
  typedef struct { bit owner_b; int cyc; logic [DW-1:0] r1; logic [DW-1:0] r2; } val_ev_t;
  typedef struct { int cyc; logic [AW-1:0] addr; logic [DW-1:0] data; } wr_ev_t;

  gnt_ev_t gq[$];
  val_ev_t vq[$];
  wr_ev_t  wq[$];
  int both_gnt = 0;
  int both_val = 0;
  int rd_cnt   = 0;

  always @(negedge clk) begin : mon
    gnt_ev_t g;
    val_ev_t v;
    wr_ev_t  w;
    if (gnt_a && gnt_b) both_gnt++;
    if (val_a && val_b) both_val++;
    if (gnt_a || gnt_b) begin
      g.owner_b = gnt_b && !gnt_a;
      g.cyc = cyc; g.req_a = req_a; g.req_b = req_b;
      g.wr    = g.owner_b ? wr_b    : wr_a;
      g.rd1   = g.owner_b ? rd1_b   : rd1_a;
      g.rd2   = g.owner_b ? rd2_b   : rd2_a;
      g.waddr = g.owner_b ? waddr_b : waddr_a;
      g.wdata = g.owner_b ? wdata_b : wdata_a;
      gq.push_back(g);
    end
    if (val_a || val_b) begin
      v.owner_b = val_b && !val_a; v.cyc = cyc; v.r1 = rdata1; v.r2 = rdata2;
      vq.push_back(v);
    end
    if (sig_write) begin
      w.cyc = cyc; w.addr = waddr_o; w.data = wdata_o;
      wq.push_back(w);
    end
    if (sig_read) rd_cnt++;
  end

  // ---------------- transaction-level model ----------------
  logic [DW-1:0] shadow [16];
  bit            model_last_b;

  // The winner of a tie is the requester that was not granted last (in the
  // round-robin build), or A (in the fixed build). Reads return the contents
  // from before this transaction, and the write is applied afterwards.
  task automatic model_txn(input gnt_ev_t g, output bit exp_b,
                           output logic [DW-1:0] e1, output logic [DW-1:0] e2);
`ifdef REGBANK_ARB_ROUND_ROBIN_EN
    exp_b = g.req_b && (!g.req_a || !model_last_b);
`else
    exp_b = g.req_b && !g.req_a;
`endif
    e1 = shadow[g.rd1];
    e2 = shadow[g.rd2];
    if (g.wr) shadow[g.waddr] = g.wdata;
    model_last_b = g.owner_b;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    gq.delete(); vq.delete(); wq.delete(); rd_cnt = 0;
  endtask

  // Raise Req with the given fields, wait (bounded) for the grant, then drop Req.
  task automatic drive(input bit who_b, input bit wr, input logic [AW-1:0] r1,
                       input logic [AW-1:0] r2, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, output bit ok);
    ok = 1'b0;
    if (who_b) begin
      wr_b = wr; rd1_b = r1; rd2_b = r2; waddr_b = wa; wdata_b = wd; req_b = 1'b1;
    end else begin
      wr_a = wr; rd1_a = r1; rd2_a = r2; waddr_a = wa; wdata_a = wd; req_a = 1'b1;
    end
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      ok = who_b ? gnt_b : gnt_a;
    end
    @(posedge clk);
    #1;
    if (who_b) req_b = 1'b0; else req_a = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; bank_init = 1'b1; req_a = 1'b1;
    tick(3);
    total++; if ((gnt_a | gnt_b) !== 1'b0) begin bad++; $display("FAIL rst_gnt: got %b required 0", gnt_a | gnt_b); end
    total++; if ((val_a | val_b) !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b required 0", val_a | val_b); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b required 0", busy); end
    total++; if ({sig_write, sig_read} !== 2'b00) begin bad++; $display("FAIL rst_strobes: got %b required 00", {sig_write, sig_read}); end
    total++; if ({rd_1, rd_2, waddr_o} !== '0) begin bad++; $display("FAIL rst_addr: got %h required 0", {rd_1, rd_2, waddr_o}); end
    total++; if (wdata_o !== '0) begin bad++; $display("FAIL rst_wdata: got %h required 0", wdata_o); end
    total++; if ({rdata1, rdata2} !== '0) begin bad++; $display("FAIL rst_rdata: got %h required 0", {rdata1, rdata2}); end
    rst = 1'b0; req_a = 1'b0; bank_init = 1'b0;
    for (int i = 0; i < 16; i++) shadow[i] = init_val(i);
    model_last_b = 1'b1;
    tick(2);
    total++; if (gq.size() != 0) begin bad++; $display("FAIL rst_no_grant: got %0d grants required 0", gq.size()); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_rst_busy: got %b required 0", busy); end
  endtask

  task automatic test_write_a();
    bit ok; bit eb; logic [DW-1:0] e1, e2;
    clear_q();
    drive(1'b0, 1'b1, 4'd0, 4'd1, 4'd3, 32'hDEADBEEF, ok);
    tick(5);
    total++; if (!ok) begin bad++; $display("FAIL wr_a_gnt_timeout: got no Gnt_A required Gnt_A"); end
    total++;
    if (gq.size() != 1 || vq.size() != 1 || wq.size() != 1 || rd_cnt != 1) begin
      bad++; $display("FAIL wr_a_counts: got gnt=%0d val=%0d wr=%0d rd=%0d required 1 each",
                      gq.size(), vq.size(), wq.size(), rd_cnt);
    end else begin
      model_txn(gq[0], eb, e1, e2);
      total++; if (gq[0].owner_b !== 1'b0 || vq[0].owner_b !== 1'b0) begin bad++; $display("FAIL wr_a_owner: got gnt_b=%b val_b=%b required A", gq[0].owner_b, vq[0].owner_b); end
      total++; if (wq[0].cyc != gq[0].cyc + 1) begin bad++; $display("FAIL wr_a_write_cycle: got %0d required %0d", wq[0].cyc, gq[0].cyc + 1); end
      total++; if (wq[0].addr !== 4'd3 || wq[0].data !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_a_write_fields: got %h/%h required 3/deadbeef", wq[0].addr, wq[0].data); end
      total++; if (vq[0].cyc - gq[0].cyc != 3) begin bad++; $display("FAIL wr_a_latency: got %0d required 3", vq[0].cyc - gq[0].cyc); end
      total++; if (vq[0].r1 !== e1 || vq[0].r2 !== e2) begin bad++; $display("FAIL wr_a_rdata: got %h/%h required %h/%h", vq[0].r1, vq[0].r2, e1, e2); end
    end
  endtask

  task automatic test_read_b();
    bit ok; bit eb; logic [DW-1:0] e1, e2;
    clear_q();
    drive(1'b1, 1'b0, 4'd3, 4'd1, 4'd0, 32'h0, ok);
    tick(5);
    total++;
    if (!ok || gq.size() != 1 || vq.size() != 1 || wq.size() != 0) begin
      bad++; $display("FAIL rd_b_counts: got ok=%b gnt=%0d val=%0d wr=%0d required 1/1/1/0", ok, gq.size(), vq.size(), wq.size());
    end else begin
      model_txn(gq[0], eb, e1, e2);
      total++; if (vq[0].owner_b !== 1'b1 || vq[0].cyc - gq[0].cyc != 3) begin bad++; $display("FAIL rd_b_valid: got owner_b=%b lat=%0d required 1/3", vq[0].owner_b, vq[0].cyc - gq[0].cyc); end
      total++; if (vq[0].r1 !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_b_rdata1: got %h required deadbeef", vq[0].r1); end
      total++; if (vq[0].r2 !== e2) begin bad++; $display("FAIL rd_b_rdata2: got %h required %h", vq[0].r2, e2); end
    end
    total++; if (rdata1 !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_b_hold: got %h required deadbeef", rdata1); end
  endtask

  task automatic test_no_bypass();
    bit ok1, ok2;
    clear_q();
    drive(1'b0, 1'b1, 4'd5, 4'd5, 4'd5, 32'h00001234, ok1);
    tick(4);
    drive(1'b1, 1'b0, 4'd5, 4'd3, 4'd0, 32'h0, ok2);
    tick(5);
    total++;
    if (!ok1 || !ok2 || vq.size() != 2) begin
      bad++; $display("FAIL nobyp_counts: got ok=%b%b val=%0d required 11/2", ok1, ok2, vq.size());
    end else begin
      total++; if (vq[0].r1 !== 32'h0) begin bad++; $display("FAIL nobyp_same_txn: got %h required 0", vq[0].r1); end
      total++; if (vq[1].r1 !== 32'h00001234) begin bad++; $display("FAIL nobyp_next_read: got %h required 1234", vq[1].r1); end
    end
    shadow[5] = 32'h00001234;
    model_last_b = 1'b1;
  endtask

  task automatic test_back_to_back();
    bit eb; bit want_b; logic [DW-1:0] e1, e2;
    clear_q();
    wr_a = 1'b0; rd1_a = 4'd3; rd2_a = 4'd5; waddr_a = 4'd0; wdata_a = '0;
    wr_b = 1'b0; rd1_b = 4'd1; rd2_b = 4'd3; waddr_b = 4'd0; wdata_b = '0;
    req_a = 1'b1; req_b = 1'b1;
    tick(12);
    req_a = 1'b0; req_b = 1'b0;
    tick(5);
    total++;
    if (gq.size() != 4 || vq.size() != 4) begin
      bad++; $display("FAIL b2b_counts: got gnt=%0d val=%0d required 4/4", gq.size(), vq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
`ifdef REGBANK_ARB_ROUND_ROBIN_EN
        want_b = (i % 2) == 1;
`else
        want_b = 1'b0;
`endif
        model_txn(gq[i], eb, e1, e2);
        total++; if (gq[i].owner_b !== want_b) begin bad++; $display("FAIL b2b_order[%0d]: got B=%b required B=%b", i, gq[i].owner_b, want_b); end
        total++; if (vq[i].r1 !== e1 || vq[i].r2 !== e2 || vq[i].owner_b !== want_b) begin bad++; $display("FAIL b2b_rdata[%0d]: got %h/%h required %h/%h", i, vq[i].r1, vq[i].r2, e1, e2); end
        if (i > 0) begin
          total++; if (gq[i].cyc - gq[i-1].cyc != 3) begin bad++; $display("FAIL b2b_spacing[%0d]: got %0d required 3", i, gq[i].cyc - gq[i-1].cyc); end
        end
      end
    end
  endtask

  task automatic test_busy_hold();
    bit got_a, got_b; int ca, cb;
    clear_q();
    got_a = 1'b0; got_b = 1'b0; ca = 0; cb = 0;
    wr_a = 1'b0; rd1_a = 4'd2; rd2_a = 4'd4; req_a = 1'b1;
    for (int k = 0; k < 20 && !got_a; k++) begin @(negedge clk); if (gnt_a) begin got_a = 1'b1; ca = cyc; end end
    @(posedge clk); #1;
    req_a = 1'b0;
    wr_b = 1'b0; rd1_b = 4'd6; rd2_b = 4'd7; req_b = 1'b1;
    for (int k = 0; k < 20 && !got_b; k++) begin @(negedge clk); if (gnt_b) begin got_b = 1'b1; cb = cyc; end end
    @(posedge clk); #1;
    req_b = 1'b0;
    tick(5);
    total++; if (!got_a || !got_b) begin bad++; $display("FAIL busy_grants: got A=%b B=%b required 1/1", got_a, got_b); end
    total++; if (cb - ca != 3) begin bad++; $display("FAIL busy_gnt_b_cycle: got %0d required 3", cb - ca); end
    model_last_b = 1'b1;
  endtask

  task automatic test_reset_mid_issue();
    bit ok; bit eb; logic [DW-1:0] e1, e2;
    clear_q();
    drive(1'b0, 1'b1, 4'd7, 4'd7, 4'd7, 32'hCAFEF00D, ok);
    #1;
    total++; if (sig_write !== 1'b1) begin bad++; $display("FAIL rmi_issue_write: got %b required 1", sig_write); end
    rst = 1'b1;
    #1;
    total++; if (sig_write !== 1'b0 || sig_read !== 1'b0) begin bad++; $display("FAIL rmi_strobes: got %b%b required 00", sig_write, sig_read); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmi_busy: got %b required 0", busy); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_last_b = 1'b1;
    tick(5);
    total++; if (vq.size() != 0 || wq.size() != 0) begin bad++; $display("FAIL rmi_dropped: got val=%0d wr=%0d required 0/0", vq.size(), wq.size()); end
    total++; if (mem[7] !== shadow[7]) begin bad++; $display("FAIL rmi_bank7: got %h required %h", mem[7], shadow[7]); end
    clear_q();
    drive(1'b0, 1'b0, 4'd7, 4'd3, 4'd0, 32'h0, ok);
    tick(5);
    total++;
    if (!ok || gq.size() != 1 || vq.size() != 1) begin
      bad++; $display("FAIL rmi_after_counts: got ok=%b gnt=%0d val=%0d required 1/1/1", ok, gq.size(), vq.size());
    end else begin
      model_txn(gq[0], eb, e1, e2);
      total++; if (vq[0].r1 !== e1 || vq[0].cyc - gq[0].cyc != 3) begin bad++; $display("FAIL rmi_after_read: got %h lat=%0d required %h lat=3", vq[0].r1, vq[0].cyc - gq[0].cyc, e1); end
    end
  endtask

  task automatic test_random();
    bit eb; logic [DW-1:0] e1, e2; int wi;
    clear_q();
    fork
      begin
        bit ok;
        for (int t = 0; t < 20; t++) begin
          tick($urandom_range(0, 3));
          drive(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), $urandom, ok);
          total++; if (!ok) begin bad++; $display("FAIL rand_a_timeout: got no Gnt_A required Gnt_A (txn %0d)", t); end
        end
      end
      begin
        bit ok;
        for (int t = 0; t < 20; t++) begin
          tick($urandom_range(0, 3));
          drive(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), $urandom, ok);
          total++; if (!ok) begin bad++; $display("FAIL rand_b_timeout: got no Gnt_B required Gnt_B (txn %0d)", t); end
        end
      end
    join
    tick(6);
    total++;
    if (vq.size() != gq.size()) begin
      bad++; $display("FAIL rand_counts: got val=%0d required %0d", vq.size(), gq.size());
    end else begin
      wi = 0;
      foreach (gq[i]) begin
        model_txn(gq[i], eb, e1, e2);
        total++; if (gq[i].owner_b !== eb) begin bad++; $display("FAIL rand_arb[%0d]: got B=%b required B=%b", i, gq[i].owner_b, eb); end
        total++; if (vq[i].owner_b !== gq[i].owner_b || vq[i].cyc - gq[i].cyc != 3) begin bad++; $display("FAIL rand_valid[%0d]: got owner_b=%b lat=%0d required %b/3", i, vq[i].owner_b, vq[i].cyc - gq[i].cyc, gq[i].owner_b); end
        total++; if (vq[i].r1 !== e1 || vq[i].r2 !== e2) begin bad++; $display("FAIL rand_rdata[%0d]: got %h/%h required %h/%h", i, vq[i].r1, vq[i].r2, e1, e2); end
        if (i > 0) begin
          total++; if (gq[i].cyc - gq[i-1].cyc < 3) begin bad++; $display("FAIL rand_spacing[%0d]: got %0d required >=3", i, gq[i].cyc - gq[i-1].cyc); end
        end
        if (gq[i].wr) begin
          total++;
          if (wi >= wq.size()) begin
            bad++; $display("FAIL rand_write_missing[%0d]: got none required write", i);
          end else if (wq[wi].cyc != gq[i].cyc + 1 || wq[wi].addr !== gq[i].waddr || wq[wi].data !== gq[i].wdata) begin
            bad++; $display("FAIL rand_write[%0d]: got c%0d %h/%h required c%0d %h/%h", i, wq[wi].cyc, wq[wi].addr, wq[wi].data, gq[i].cyc + 1, gq[i].waddr, gq[i].wdata);
          end
          wi++;
        end
      end
      total++; if (wi != wq.size()) begin bad++; $display("FAIL rand_write_count: got %0d required %0d", wq.size(), wi); end
    end
    total++; if (both_gnt != 0 || both_val != 0) begin bad++; $display("FAIL exclusive: got both_gnt=%0d both_val=%0d required 0/0", both_gnt, both_val); end
  endtask

  initial begin
    rst = 1'b1; bank_init = 1'b1;
    req_a = 1'b0; req_b = 1'b0; wr_a = 1'b0; wr_b = 1'b0;
    rd1_a = '0; rd2_a = '0; rd1_b = '0; rd2_b = '0;
    waddr_a = '0; waddr_b = '0; wdata_a = '0; wdata_b = '0;
    test_reset();
    test_write_a();
    test_read_b();
    test_no_bypass();
    test_back_to_back();
    test_busy_hold();
    test_reset_mid_issue();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion required finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regbank_arbiter.md
REGBANK_ARBITER -- requirements
Module: regbank_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 4: register address width.
REQ-002 SHALL have parameter DATA_W, default 32: register data width.
REQ-003 Clock_in  in  1  single clock; all state changes on posedge.
REQ-004 Signal_reset  in  1  asynchronous, active-high reset.
REQ-005 Req_A / Req_B  in  1 each  transaction request from requester A / B.
REQ-006 Wr_A / Wr_B  in  1 each  transaction includes a write.
REQ-007 Rd1_A, Rd2_A / Rd1_B, Rd2_B  in  ADDR_W each  read addresses.
REQ-008 Waddr_A / Waddr_B  in  ADDR_W each  write address.
REQ-009 Wdata_A / Wdata_B  in  DATA_W each  write data.
REQ-010 Gnt_A / Gnt_B  out  1 each  one-cycle pulse: request latched.
REQ-011 Valid_A / Valid_B  out  1 each  one-cycle pulse: Rdata1/Rdata2 valid for that requester.
REQ-012 Rdata1 / Rdata2  out  DATA_W each  read results, shared by both requesters.
REQ-013 Read_1, Read_2, Address_to_write  out  ADDR_W each  to register bank.
REQ-014 Data_to_write  out  DATA_W  to register bank.
REQ-015 Signal_write, Signal_read  out  1 each  bank strobes.
REQ-016 Out_1, Out_2  in  DATA_W each  bank read outputs (registered in the bank on posedge).
REQ-017 Busy  out  1  high whenever state is not IDLE.

Function
REQ-018 FSM SHALL have states IDLE, ISSUE, CAPTURE; IDLE->ISSUE on any Req in IDLE; ISSUE->CAPTURE unconditionally; CAPTURE->IDLE unconditionally.
REQ-019 In IDLE with a Req, SHALL select the winner, latch its Wr/Rd1/Rd2/Waddr/Wdata and owner, and pulse its Gnt in that same cycle.
REQ-020 With both Req high, winner SHALL be the requester not granted most recently; the pointer updates only on a grant; pointer reset value favours A.
REQ-021 In ISSUE, SHALL drive latched addresses/data to the bank with Signal_read=1 and Signal_write=latched Wr, for exactly one cycle; strobes 0 in all other states.
REQ-022 In CAPTURE, SHALL register Out_1/Out_2 into Rdata1/Rdata2 and pulse the owner's Valid in the following cycle (Gnt-to-Valid latency 3 cycles).
REQ-023 Rdata1/Rdata2 SHALL hold their value until the next Valid.
REQ-024 When write address equals a read address in one transaction, the read SHALL return the pre-write value (no bypass).
REQ-025 Requests arriving while Busy SHALL be ignored until IDLE; requesters hold Req and fields until Gnt; peak throughput one transaction per 3 cycles.
REQ-026 Gnt_A and Gnt_B SHALL never both be high; Valid_A and Valid_B SHALL never both be high.

Reset
REQ-027 On Signal_reset, SHALL asynchronously enter IDLE, drop any in-flight transaction (no write strobe after reset asserts), and clear Gnt*, Valid*, Busy, strobes, bank address/data outputs and Rdata1/Rdata2 to 0.
REQ-028 Reset mid-ISSUE SHALL deassert Signal_write combinationally-free, i.e. from the reset register state, within the reset cycle.

Configuration
REQ-029 Macro REGBANK_ARB_ROUND_ROBIN_EN defined: arbitration per REQ-020.
REQ-030 Macro REGBANK_ARB_ROUND_ROBIN_EN undefined: fixed priority, A always wins a tie; no pointer register exists.

Verification
REQ-031 Reset, then Req_A write Waddr_A=3, Wdata_A=0xDEADBEEF -> Gnt_A pulse, one Signal_write cycle with Address_to_write=3, Valid_A 3 cycles after Gnt_A.
REQ-032 Req_B read Rd1_B=3, Rd2_B=1 after REQ-031 -> Valid_B with Rdata1=0xDEADBEEF, Rdata2=Out_2 of bank register 1.
REQ-033 Req_A and Req_B held high 12 cycles -> grants alternate A,B,A,B (round-robin build); A,A,A,A (fixed build).
REQ-034 Write Waddr=5 data 0x1234 with Rd1=5, bank reg5=0 -> Rdata1=0; next read of 5 -> 0x1234.
REQ-035 Signal_reset asserted during ISSUE -> Signal_write low immediately, no Valid pulse, Busy=0, next Req granted normally.
REQ-036 Req_B rises while Busy from A -> no Gnt_B until FSM returns to IDLE; Gnt_B in the first IDLE cycle.
